// File: rtl/multicycle_main_fsm_pkg.sv
// Shared control definitions for the RV32I cores: FSM states, opcodes,
// ALUOp codes and datapath mux-select encodings.
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10
    } statetype;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Raw per-state decode before reset gating and the zero/branch combine.
    typedef struct packed {
        logic       adrSrc;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       irWrite;
        logic       pcUpdate;
        logic       branch;
        logic       memWrite;
        logic       regWrite;
        logic       instrDone;
        logic       illegalOp;
    } ctrl_t;

    function automatic logic isSupportedOp(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath (slave).
interface multicycle_main_fsm_if;

    logic [6:0] op;
    logic       zero;
    logic       memReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       instrDone;
    logic       illegalOp;

    modport master (
        input  op, zero, memReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instrDone, illegalOp
    );

    modport slave (
        output op, zero, memReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instrDone, illegalOp
    );

endinterface

// File: rtl/multicycle_main_fsm_instrDecoder.sv
// Opcode to immediate-format decode; purely combinational so the pipelined core can reuse it.
module instrDecoder
    import core_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    output logic [1:0] immSrc_o
);

    always_comb begin
        immSrc_o = IMM_I;
        case (op_i)
            OP_SW:   immSrc_o = IMM_S;
            OP_BEQ:  immSrc_o = IMM_B;
            OP_JAL:  immSrc_o = IMM_J;
            default: immSrc_o = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/writeback
// on the shared datapath, with optional wait states on the memory port.
module multicycle_main_fsm
    import core_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_main_fsm_if.master bus
);

    statetype   state_q, state_d;
    ctrl_t      ctrl;
    logic       memRdy;
    logic [1:0] immSrc;

    assign memRdy = MEM_HANDSHAKE ? bus.memReady : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = memRdy ? DECODE : FETCH;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_LW)      state_d = MEMREAD;
                else if (bus.op == OP_SW) state_d = MEMWRITE;
                else                      state_d = FETCH;
            end
            MEMREAD:  state_d = memRdy ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = memRdy ? FETCH : MEMWRITE;
            EXECUTER, EXECUTEI, JAL: state_d = ALUWB;
            ALUWB, BEQ: state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            FETCH: begin
                ctrl.resultSrc = RES_ALURESULT;
                ctrl.aluSrcA   = SRCA_PC;
                ctrl.aluSrcB   = SRCB_FOUR;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.irWrite   = memRdy;
                ctrl.pcUpdate  = memRdy;
            end
            DECODE: begin
                // Precompute the branch/jal target into ALUOut while the op is decoded.
                ctrl.aluSrcA   = SRCA_OLDPC;
                ctrl.aluSrcB   = SRCB_IMM;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.illegalOp = ~isSupportedOp(bus.op);
            end
            MEMADR: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_ADD;
            end
            MEMREAD: begin
                ctrl.adrSrc    = 1'b1;
                ctrl.resultSrc = RES_ALUOUT;
            end
            MEMWB: begin
                ctrl.resultSrc = RES_DATA;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEMWRITE: begin
                ctrl.adrSrc    = 1'b1;
                ctrl.resultSrc = RES_ALUOUT;
                ctrl.memWrite  = 1'b1;
                ctrl.instrDone = memRdy;
            end
            EXECUTER: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_RS2;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ctrl.aluSrcA = SRCA_RS1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            JAL: begin
                ctrl.aluSrcA   = SRCA_OLDPC;
                ctrl.aluSrcB   = SRCB_FOUR;
                ctrl.aluOp     = ALUOP_ADD;
                ctrl.resultSrc = RES_ALUOUT;
                ctrl.pcUpdate  = 1'b1;
            end
            ALUWB: begin
                ctrl.resultSrc = RES_ALUOUT;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            BEQ: begin
                ctrl.aluSrcA   = SRCA_RS1;
                ctrl.aluSrcB   = SRCB_RS2;
                ctrl.aluOp     = ALUOP_SUB;
                ctrl.resultSrc = RES_ALUOUT;
                ctrl.branch    = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    instrDecoder u_instrDecoder (
        .op_i     (bus.op),
        .immSrc_o (immSrc)
    );

    // Strobes are masked by rst directly so they drop without waiting for the state register.
    assign bus.PCWrite   = ~rst & ((ctrl.branch & bus.zero) | ctrl.pcUpdate);
    assign bus.IRWrite   = ~rst & ctrl.irWrite;
    assign bus.MemWrite  = ~rst & ctrl.memWrite;
    assign bus.RegWrite  = ~rst & ctrl.regWrite;
    assign bus.instrDone = ~rst & ctrl.instrDone;
    assign bus.illegalOp = ~rst & ctrl.illegalOp;
    assign bus.AdrSrc    = ctrl.adrSrc;
    assign bus.ResultSrc = ctrl.resultSrc;
    assign bus.ALUSrcA   = ctrl.aluSrcA;
    assign bus.ALUSrcB   = ctrl.aluSrcB;
    assign bus.ALUOp     = ctrl.aluOp;
    assign bus.ImmSrc    = immSrc;

endmodule
